// File: rtl/pipelined_add_sub.sv
// Pipelined two's-complement adder/subtractor: the carry chain is cut into
// STAGES slices of C bits, one register rank per slice, in-order valid/ready.
module pipelined_add_sub #(
  parameter int WIDTH  = 64,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             inValid,
  output logic             inReady,
  output logic [WIDTH-1:0] s,
  output logic             carry,
  output logic             overflow,
  output logic             zero,
  output logic             outValid,
  input  logic             outReady
);
  localparam int C = WIDTH / STAGES;

  // Handshake: data moves on a rising edge where valid && ready. ready never
  // depends on valid; a stage is free when it is empty or its content leaves
  // this cycle, so bubbles collapse and a full pipe frozen by outReady=0 stalls.
  logic [STAGES-1:0] v_vec;
  logic [STAGES-1:0] c_vec;
  logic [STAGES-1:0] free;
  logic              free_acc;
  logic [WIDTH-1:0]  a_arr  [STAGES];
  logic [WIDTH-1:0]  bx_arr [STAGES];
  logic [WIDTH-1:0]  s_arr  [STAGES];
  logic              unused_bits;

  always_comb begin
    free_acc = outReady;
    free     = '0;
    for (int k = STAGES - 1; k >= 0; k--) begin
      free_acc = free_acc || !v_vec[k];
      free[k]  = free_acc;
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [WIDTH-1:0] src_a, src_bx, src_s, new_s;
    logic             src_c, src_v;
    logic [C:0]       slice;
    logic [WIDTH-1:0] a_q, a_d, bx_q, bx_d, s_q, s_d;
    logic             v_q, v_d, c_q, c_d;

    if (k == 0) begin : g_first
      assign src_a  = a;
      assign src_bx = b ^ {WIDTH{sub}};
      assign src_s  = '0;
      assign src_c  = sub;
      assign src_v  = inValid;
    end else begin : g_next
      assign src_a  = a_arr[k-1];
      assign src_bx = bx_arr[k-1];
      assign src_s  = s_arr[k-1];
      assign src_c  = c_vec[k-1];
      assign src_v  = v_vec[k-1];
    end

    assign slice = {1'b0, src_a[k*C +: C]} + {1'b0, src_bx[k*C +: C]} + {{C{1'b0}}, src_c};

    always_comb begin
      new_s           = src_s;
      new_s[k*C +: C] = slice[C-1:0];
      v_d             = free[k] ? src_v : v_q;
      a_d             = a_q;
      bx_d            = bx_q;
      s_d             = s_q;
      c_d             = c_q;
      if (free[k] && src_v) begin
        a_d  = src_a;
        bx_d = src_bx;
        s_d  = new_s;
        c_d  = slice[C];
      end
    end

    always_ff @(posedge clk) begin
      if (!reset_n) begin
        v_q  <= 1'b0;
        c_q  <= 1'b0;
        a_q  <= '0;
        bx_q <= '0;
        s_q  <= '0;
      end else begin
        v_q  <= v_d;
        c_q  <= c_d;
        a_q  <= a_d;
        bx_q <= bx_d;
        s_q  <= s_d;
      end
    end

    assign v_vec[k]  = v_q;
    assign c_vec[k]  = c_q;
    assign a_arr[k]  = a_q;
    assign bx_arr[k] = bx_q;
    assign s_arr[k]  = s_q;

    // The last rank is the output register; its flags see the whole sum.
    if (k == STAGES - 1) begin : g_flags
      logic ovf_q, ovf_d, zero_q, zero_d;

      always_comb begin
        ovf_d  = ovf_q;
        zero_d = zero_q;
        if (free[k] && src_v) begin
          ovf_d  = (src_a[WIDTH-1] == src_bx[WIDTH-1]) && (new_s[WIDTH-1] != src_a[WIDTH-1]);
          zero_d = (new_s == '0);
        end
      end

      always_ff @(posedge clk) begin
        if (!reset_n) begin
          ovf_q  <= 1'b0;
          zero_q <= 1'b0;
        end else begin
          ovf_q  <= ovf_d;
          zero_q <= zero_d;
        end
      end

      assign overflow = ovf_q;
      assign zero     = zero_q;
    end
  end

  // Operand bits below the consumed slice are dead once a stage is loaded.
  always_comb begin
    unused_bits = 1'b0;
    for (int k = 0; k < STAGES; k++) begin
      unused_bits = unused_bits ^ (^a_arr[k]) ^ (^bx_arr[k]) ^ (^s_arr[k]);
    end
  end

  assign s        = s_arr[STAGES-1];
  assign carry    = c_vec[STAGES-1];
  assign outValid = v_vec[STAGES-1];
  assign inReady  = free[0];

endmodule

// File: tb/tb_pipelined_add_sub.sv
// Bench for pipelined_add_sub: three instances (64/4, 32/1, 64/8) scored
// against an arithmetic reference model through one tagged expected queue.
module tb_pipelined_add_sub;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [2:0]  iv, isub, ordy;
  logic [63:0] ia [3];
  logic [63:0] ib [3];
  logic [2:0]  in_rdy, out_vld, c_n, o_n, z_n;
  logic [63:0] s_n [3];
  logic [63:0] s0w, s2w;
  logic [31:0] s1w;

  int n_total = 0;
  int n_bad   = 0;
  logic [68:0] exp_q[$];
  logic [2:0]  hold_v;
  logic [66:0] hold_obs [3];
  logic [66:0] m_obs;
  logic        m_found;
  int          m_idx;

  always #5 clk = ~clk;

  pipelined_add_sub #(.WIDTH(64), .STAGES(4)) u_dut4 (
    .clk(clk), .reset_n(reset_n), .a(ia[0]), .b(ib[0]), .sub(isub[0]),
    .inValid(iv[0]), .inReady(in_rdy[0]), .s(s0w), .carry(c_n[0]),
    .overflow(o_n[0]), .zero(z_n[0]), .outValid(out_vld[0]), .outReady(ordy[0]));

  pipelined_add_sub #(.WIDTH(32), .STAGES(1)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .a(ia[1][31:0]), .b(ib[1][31:0]), .sub(isub[1]),
    .inValid(iv[1]), .inReady(in_rdy[1]), .s(s1w), .carry(c_n[1]),
    .overflow(o_n[1]), .zero(z_n[1]), .outValid(out_vld[1]), .outReady(ordy[1]));

  pipelined_add_sub #(.WIDTH(64), .STAGES(8)) u_dut8 (
    .clk(clk), .reset_n(reset_n), .a(ia[2]), .b(ib[2]), .sub(isub[2]),
    .inValid(iv[2]), .inReady(in_rdy[2]), .s(s2w), .carry(c_n[2]),
    .overflow(o_n[2]), .zero(z_n[2]), .outValid(out_vld[2]), .outReady(ordy[2]));

  assign s_n[0] = s0w;
  assign s_n[1] = {32'h0, s1w};
  assign s_n[2] = s2w;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int width_of(input int id);
    return (id == 1) ? 32 : 64;
  endfunction

  // Reference: plain integer add/subtract; flags from unsigned and signed ranges.
  function automatic logic [66:0] ref_model(input int w, input logic [63:0] a, input logic [63:0] b,
                                            input logic sub);
    logic [63:0]        mask, sres;
    logic [66:0]        ua, ub, ur;
    logic signed [66:0] sa, sb, sr, lim;
    logic               c, o, z;
    mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    ua   = {3'b0, a & mask};
    ub   = {3'b0, b & mask};
    ur   = sub ? (ua - ub) : (ua + ub);
    sres = ur[63:0] & mask;
    c    = sub ? (ua >= ub) : (ur >= (67'd1 << w));
    sa   = $signed(ua);
    sb   = $signed(ub);
    if (ua[w-1]) sa = sa - $signed(67'd1 << w);
    if (ub[w-1]) sb = sb - $signed(67'd1 << w);
    sr   = sub ? (sa - sb) : (sa + sb);
    lim  = $signed(67'd1 << (w - 1));
    o    = (sr >= lim) || (sr < -lim);
    z    = (sres == 64'd0);
    return {sres, c, o, z};
  endfunction

  function automatic logic [63:0] rnd64();
    case ($urandom_range(0, 5))
      0: return 64'hFFFF_FFFF_FFFF_FFFF;
      1: return 64'h7FFF_FFFF_FFFF_FFFF;
      2: return 64'h8000_0000_0000_0000;
      3: return 64'h0;
      4: return 64'($urandom_range(0, 15));
      default: return {$urandom, $urandom};
    endcase
  endfunction

  function automatic int pending(input int id);
    int n = 0;
    foreach (exp_q[j]) if (exp_q[j][68:67] == 2'(id)) n++;
    return n;
  endfunction

  // Scoreboard: push the model result on every accept, pop on every delivery.
  always @(negedge clk) begin
    for (int id = 0; id < 3; id++) begin
      m_obs = {s_n[id], c_n[id], o_n[id], z_n[id]};
      if (!reset_n) begin
        for (int j = exp_q.size() - 1; j >= 0; j--)
          if (exp_q[j][68:67] == 2'(id)) exp_q.delete(j);
        hold_v[id] = 1'b0;
      end else begin
        if (iv[id] && in_rdy[id])
          exp_q.push_back({2'(id), ref_model(width_of(id), ia[id], ib[id], isub[id])});
        if (out_vld[id] && ordy[id]) begin
          m_found = 1'b0;
          m_idx   = 0;
          for (int j = 0; j < exp_q.size(); j++)
            if (!m_found && exp_q[j][68:67] == 2'(id)) begin
              m_found = 1'b1;
              m_idx   = j;
            end
          chk($sformatf("orphan%0d", id), m_found, 1);
          if (m_found) begin
            chk($sformatf("res%0d", id), m_obs, exp_q[m_idx][66:0]);
            exp_q.delete(m_idx);
          end
        end
        if (out_vld[id] && !ordy[id]) begin
          if (hold_v[id]) chk($sformatf("hold%0d", id), m_obs, hold_obs[id]);
          hold_v[id]   = 1'b1;
          hold_obs[id] = m_obs;
        end else begin
          hold_v[id] = 1'b0;
        end
      end
    end
  end

  // Call right after a rising edge; returns after the accepting edge.
  task automatic send(input int id, input logic [63:0] a, input logic [63:0] b, input logic sub);
    int   n = 0;
    logic ok = 1'b0;
    iv[id] = 1'b1; ia[id] = a; ib[id] = b; isub[id] = sub;
    while (!ok && n < 100) begin
      @(negedge clk);
      ok = in_rdy[id];
      n++;
      @(posedge clk); #1;
    end
    iv[id] = 1'b0;
    chk("accept", ok, 1);
  endtask

  task automatic wait_out(input int id, output int lat);
    lat = 1;
    @(negedge clk);
    while (!out_vld[id] && lat < 100) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
  endtask

  task automatic drain(input int id);
    int n = 0;
    ordy[id] = 1'b1;
    while (pending(id) > 0 && n < 300) begin
      @(posedge clk);
      n++;
    end
    @(negedge clk);
    chk($sformatf("drain%0d", id), pending(id), 0);
  endtask

  task automatic rand_run(input int id, input int nops);
    int   sent = 0;
    int   cyc  = 0;
    logic fired;
    @(posedge clk); #1;
    ia[id] = rnd64(); ib[id] = rnd64(); isub[id] = 1'($urandom_range(0, 1));
    while (sent < nops && cyc < 20000) begin
      iv[id]   = 1'($urandom_range(0, 1));
      ordy[id] = 1'($urandom_range(0, 1));
      @(negedge clk);
      fired = iv[id] && in_rdy[id];
      @(posedge clk); #1;
      if (fired) begin
        sent++;
        ia[id] = rnd64(); ib[id] = rnd64(); isub[id] = 1'($urandom_range(0, 1));
      end
      cyc++;
    end
    iv[id] = 1'b0;
    chk($sformatf("sent%0d", id), sent, nops);
    drain(id);
  endtask

  initial begin
    int lat, k, first, last, nout, cnt;
    logic rdy_all;
    logic [63:0] opa [6];
    logic [63:0] opb [6];
    logic [5:0]  opsub;

    iv = '0; isub = '0; ordy = '1; hold_v = '0;
    for (int id = 0; id < 3; id++) begin ia[id] = '0; ib[id] = '0; end
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    for (int id = 0; id < 3; id++) begin
      chk($sformatf("rst_ov%0d", id), out_vld[id], 0);
      chk($sformatf("rst_s%0d", id), s_n[id], 0);
      chk($sformatf("rst_flags%0d", id), {c_n[id], o_n[id], z_n[id]}, 0);
      chk($sformatf("rst_rdy%0d", id), in_rdy[id], 1);
    end

    // Carry ripples through every slice.
    @(posedge clk); #1;
    send(0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0);
    wait_out(0, lat);
    chk("t1_lat", lat, 4);
    chk("t1_s", s_n[0], 64'd0);
    chk("t1_czo", {c_n[0], z_n[0], o_n[0]}, 3'b110);

    @(posedge clk); #1;
    send(0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0);
    wait_out(0, lat);
    chk("t2a_s", s_n[0], 64'h8000_0000_0000_0000);
    chk("t2a_cvz", {c_n[0], o_n[0], z_n[0]}, 3'b010);
    @(posedge clk); #1;
    send(0, 64'd5, 64'd7, 1'b1);
    wait_out(0, lat);
    chk("t2b_s", s_n[0], 64'hFFFF_FFFF_FFFF_FFFE);
    chk("t2b_cvz", {c_n[0], o_n[0], z_n[0]}, 3'b000);

    // Back-to-back stream at full rate.
    @(posedge clk); #1;
    first = -1; last = -1; nout = 0; rdy_all = 1'b1;
    for (int i = 0; i < 24; i++) begin
      if (i < 16) begin
        iv[0] = 1'b1; ia[0] = rnd64(); ib[0] = rnd64(); isub[0] = 1'($urandom_range(0, 1));
      end else iv[0] = 1'b0;
      @(negedge clk);
      if (i < 16 && !in_rdy[0]) rdy_all = 1'b0;
      if (out_vld[0]) begin
        nout++;
        if (first < 0) first = i;
        last = i;
      end
      @(posedge clk); #1;
    end
    chk("t3_rdy", rdy_all, 1);
    chk("t3_count", nout, 16);
    chk("t3_first", first, 4);
    chk("t3_last", last, 19);

    // Backpressure: only STAGES ops fit while the output is stalled.
    for (int i = 0; i < 6; i++) begin
      opa[i] = rnd64(); opb[i] = rnd64(); opsub[i] = 1'($urandom_range(0, 1));
    end
    ordy[0] = 1'b0; k = 0;
    for (int cyc = 0; cyc < 12; cyc++) begin
      if (k < 6) begin iv[0] = 1'b1; ia[0] = opa[k]; ib[0] = opb[k]; isub[0] = opsub[k]; end
      else iv[0] = 1'b0;
      @(negedge clk);
      if (iv[0] && in_rdy[0]) k++;
      @(posedge clk); #1;
    end
    chk("t4_acc", k, 4);
    chk("t4_inrdy", in_rdy[0], 0);
    chk("t4_ov", out_vld[0], 1);
    ordy[0] = 1'b1;
    @(negedge clk);
    chk("t4_both", {in_rdy[0], out_vld[0]}, 2'b11);
    if (iv[0] && in_rdy[0]) k++;
    @(posedge clk); #1;
    for (int cyc = 0; cyc < 20 && k < 6; cyc++) begin
      iv[0] = 1'b1; ia[0] = opa[k]; ib[0] = opb[k]; isub[0] = opsub[k];
      @(negedge clk);
      if (in_rdy[0]) k++;
      @(posedge clk); #1;
    end
    iv[0] = 1'b0;
    chk("t4_acc6", k, 6);
    drain(0);

    // Reset with three ops in flight.
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      iv[0] = 1'b1; ia[0] = rnd64(); ib[0] = rnd64(); isub[0] = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
    iv[0] = 1'b0;
    reset_n = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(negedge clk);
    chk("t6_ov", out_vld[0], 0);
    chk("t6_s", s_n[0], 64'd0);
    chk("t6_flags", {c_n[0], o_n[0], z_n[0]}, 3'b000);
    chk("t6_rdy", in_rdy[0], 1);
    cnt = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (out_vld[0]) cnt++;
    end
    chk("t6_stale", cnt, 0);

    // Random valid/ready toggling on all three geometries at once.
    fork
      rand_run(0, 300);
      rand_run(1, 1000);
      rand_run(2, 1000);
    join

    chk("q_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule

// File: doc/pipelined_add_sub.md
Name: pipelined_add_sub

Overview:
Parametrised, pipelined two's-complement adder/subtractor with a valid/ready handshake and status flags. It is the next generation of the core's general-purpose adder and serves as the ALU add/sub datapath for widths up to 64 bits. The carry chain is split into STAGES equal slices with one register per slice, so it closes timing at the full core clock. Results are delivered in order.

Parameters:
WIDTH, 64, operand/result width in bits; must be divisible by STAGES.
STAGES, 4, pipeline depth and number of carry slices; range 1..WIDTH; slice width C = WIDTH/STAGES.

Ports:
clk  in  1  core clock; all state updates on its rising edge.
reset_n  in  1  synchronous, active-low reset, sampled on the rising edge of clk.
a  in  WIDTH  operand A.
b  in  WIDTH  operand B.
sub  in  1  0 = a+b, 1 = a-b.
inValid  in  1  operands valid.
inReady  out  1  block accepts operands this cycle.
s  out  WIDTH  result.
carry  out  1  carry-out of the MSB; for subtraction 1 means no borrow (a >= b unsigned).
overflow  out  1  signed overflow.
zero  out  1  s == 0.
outValid  out  1  result/flags valid.
outReady  in  1  consumer accepts the result.

Behaviour:
- Reset (reset_n = 0 at a rising edge): all stage valid bits clear.
  - outValid = 0, s = 0, carry = 0, overflow = 0, zero = 0; inReady = 1 from the first cycle after reset.
  - Reset mid-operation discards all in-flight operations; no partial result is emitted.
- Stage k (0..STAGES-1) holds a valid bit vk and a carry register ck.
  - It holds result slices [0 .. (k+1)*C-1] already computed, plus the remaining raw a and (b XOR {WIDTH{sub}}) slices.
- Arithmetic:
  - Stage 0 computes slice 0 = a[C-1:0] + b'[C-1:0] + sub.
  - Stage k computes slice k = a'[kC +: C] + b'[kC +: C] + c(k-1).
  - Results are modulo 2^WIDTH.
  - carry = carry-out of the final slice.
  - overflow = (aMSB == b'MSB) && (sMSB != aMSB), where b' is the inverted b when sub = 1.
  - zero is computed from the full s in the last stage (registered with it).
- Handshake and stalls:
  - Stage k advances when vk && (k is the last stage ? (!outValid || outReady) : (!v(k+1) || stage k+1 advances)).
  - Bubbles collapse: an empty stage accepts new data even if downstream is stalled.
  - inReady = !v0 || stage 0 advances. This is combinational from outReady through the chain; this path is accepted.
  - Transfer in occurs on inValid && inReady. Transfer out occurs on outValid && outReady.
- Output behaviour:
  - outValid, s and flags come from the output register (the last stage).
  - They hold stable while outValid && !outReady.
- Latency and throughput:
  - Latency is exactly STAGES cycles from accept to outValid when there is no backpressure.
  - Throughput is 1 op/cycle.
  - Order is preserved; capacity is STAGES operations.
- Full pipeline with outReady = 0: inReady = 0 and the pipeline is frozen.
  - When outReady rises, output and input can transfer in the same cycle.
- STAGES = 1: a single registered adder with latency 1.
- Unused register contents while a stage is invalid are don't-care internally, but s and flags only change on a transfer into the output stage.

Test Plan:
1. WIDTH=64, STAGES=4: a=0xFFFF_FFFF_FFFF_FFFF, b=1, sub=0 -> after 4 cycles s=0, carry=1, zero=1, overflow=0. Exercises the carry rippling through all slices.
2. a=0x7FFF_FFFF_FFFF_FFFF, b=1, sub=0 -> s=0x8000_0000_0000_0000, overflow=1, carry=0. Then a=5, b=7, sub=1 -> s=0xFFFF_FFFF_FFFF_FFFE, carry=0, overflow=0.
3. Back-to-back stream of 16 random ops with outReady=1 -> 16 results, one per cycle, in order, first result at cycle 4. Each matches a±b and the reference flags.
4. Hold outReady=0 while issuing 6 ops -> exactly 4 accepted, inReady=0 afterwards, output stable. Release outReady -> the 4 results drain in order, then the remaining 2 are accepted.
5. Random inValid/outReady toggling (50%) for 1000 ops at WIDTH=32, STAGES=1 and WIDTH=64, STAGES=8 -> scoreboard match, no loss or duplication.
6. Assert reset_n=0 for one cycle with 3 ops in flight -> next cycle outValid=0, s=0, flags=0, inReady=1. No stale result appears afterwards.
